// File: rtl/speed_tick_decoder_if.sv
// speed_tick_decoder_if: tick input and decoded speed outputs of the speed tick decoder.
// ChangeCount is present only when SPEED_TICK_DECODER_STATS_EN is defined.
interface speed_tick_decoder_if #(parameter int PW = 26);
    logic          TickIn;
    logic [2:0]    SpeedCode;
    logic          Valid;
    logic          Lost;
    logic [PW-1:0] PeriodOut;
`ifdef SPEED_TICK_DECODER_STATS_EN
    logic [7:0]    ChangeCount;
`endif
    modport master (
        output TickIn,
        input  SpeedCode, Valid, Lost, PeriodOut
`ifdef SPEED_TICK_DECODER_STATS_EN
        , input ChangeCount
`endif
    );
    modport slave (
        input  TickIn,
        output SpeedCode, Valid, Lost, PeriodOut
`ifdef SPEED_TICK_DECODER_STATS_EN
        , output ChangeCount
`endif
    );
endinterface

// File: rtl/speed_tick_decoder.sv
// speed_tick_decoder: measures the tick interval and decodes it to a one-hot speed code.
// Optional lock-change counter enabled by SPEED_TICK_DECODER_STATS_EN.
module speed_tick_decoder #(
    parameter int PW         = 26,
    parameter int HALF_CYC   = 25000000,
    parameter int QUART_CYC  = 12500000,
    parameter int EIGHTH_CYC = 6250000,
    parameter int TOL        = 1024
) (
    input  logic CLOCK_50,
    input  logic Reset,
    speed_tick_decoder_if.slave bus
);
    typedef enum logic [1:0] {WAIT, MEAS, LOCK} state_t;
    localparam logic [31:0] H = 32'(HALF_CYC);
    localparam logic [31:0] Q = 32'(QUART_CYC);
    localparam logic [31:0] E = 32'(EIGHTH_CYC);
    localparam logic [31:0] T = 32'(TOL);
    localparam logic [PW-1:0] TIMEOUT = PW'(HALF_CYC + TOL + 1);

    state_t        state_q, state_d;
    logic          tick_q;
    logic [PW-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [2:0]    code_q, code_d, cand_q, cand_d, cls;
    logic          valid_q, valid_d, lost_q, lost_d;
    logic          edge_s, tmo;
    logic [31:0]   p;

    function automatic logic in_win(logic [31:0] v, logic [31:0] n);
        return (v + T >= n) && (v <= n + T);
    endfunction

    assign edge_s = bus.TickIn & ~tick_q;
    assign tmo    = cnt_q >= TIMEOUT;
    assign p      = 32'(cnt_q);
    assign cls    = in_win(p, H) ? 3'b100 : in_win(p, Q) ? 3'b010 : in_win(p, E) ? 3'b001 : 3'b000;
    assign cnt_d  = edge_s ? PW'(1) : (cnt_q == '1 ? cnt_q : cnt_q + PW'(1));

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q  <= WAIT;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            code_q   <= 3'b000;
            cand_q   <= 3'b000;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= bus.TickIn;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            code_q   <= code_d;
            cand_q   <= cand_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
        end
    end

    // An edge always takes precedence over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT: state_d = edge_s ? MEAS : WAIT;
            MEAS: state_d = edge_s ? ((cls != 3'b000 && cls == cand_q) ? LOCK : MEAS) : (tmo ? WAIT : MEAS);
            LOCK: state_d = edge_s ? ((cls == code_q) ? LOCK : MEAS) : (tmo ? WAIT : LOCK);
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        period_d = period_q;
        code_d   = code_q;
        cand_d   = cand_q;
        valid_d  = valid_q;
        lost_d   = lost_q;
        case (state_q)
            WAIT: lost_d = edge_s ? 1'b0 : lost_q;
            MEAS: begin
                period_d = edge_s ? cnt_q : period_q;
                if (edge_s && cls != 3'b000 && cls == cand_q) begin
                    code_d  = cls;
                    valid_d = 1'b1;
                end else if (edge_s) begin
                    cand_d = cls;
                end else if (tmo) begin
                    cand_d = 3'b000;
                    lost_d = 1'b1;
                end
            end
            LOCK: begin
                period_d = edge_s ? cnt_q : period_q;
                if ((edge_s && cls != code_q) || (!edge_s && tmo)) begin
                    cand_d  = edge_s ? cls : 3'b000;
                    code_d  = 3'b000;
                    valid_d = 1'b0;
                    lost_d  = !edge_s;
                end
            end
            default: ;
        endcase
    end

    assign bus.SpeedCode = code_q;
    assign bus.Valid     = valid_q;
    assign bus.Lost      = lost_q;
    assign bus.PeriodOut = period_q;

`ifdef SPEED_TICK_DECODER_STATS_EN
    logic [7:0] chg_q, chg_d;
    logic [2:0] last_q, last_d;
    logic       lock_in;

    // last_q starts at 000 so the first lock after reset always counts as a change.
    assign lock_in = state_q == MEAS && state_d == LOCK;
    assign last_d  = lock_in ? cls : last_q;
    assign chg_d   = (lock_in && cls != last_q && chg_q != 8'hFF) ? chg_q + 8'd1 : chg_q;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            chg_q  <= 8'd0;
            last_q <= 3'b000;
        end else begin
            chg_q  <= chg_d;
            last_q <= last_d;
        end
    end

    assign bus.ChangeCount = chg_q;
`endif
endmodule

// File: tb/tb_speed_tick_decoder.sv
// tb_speed_tick_decoder: directed tick-interval vectors against hand-computed lock behaviour.
// Build with SPEED_TICK_DECODER_STATS_EN defined to also cover ChangeCount.
module tb_speed_tick_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    speed_tick_decoder_if #(.PW(8)) bus ();

    speed_tick_decoder #(
        .PW(8), .HALF_CYC(80), .QUART_CYC(40), .EIGHTH_CYC(20), .TOL(2)
    ) dut (
        .CLOCK_50(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Rising edge sampled p clock edges after the previous one; returns just after it.
    task automatic tick(input int p);
        repeat (p - 1) @(negedge clk);
        bus.TickIn = 1'b1;
        @(negedge clk);
        bus.TickIn = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.TickIn = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_code", 32'(bus.SpeedCode), 0);
        check("rst_valid", 32'(bus.Valid), 0);
        check("rst_lost", 32'(bus.Lost), 0);
        check("rst_period", 32'(bus.PeriodOut), 0);
`ifdef SPEED_TICK_DECODER_STATS_EN
        check("rst_chg", 32'(bus.ChangeCount), 0);
`endif
        rst = 1'b0;

        tick(1);
        tick(40);
        check("t1_valid_2nd", 32'(bus.Valid), 0);
        check("t1_period_2nd", 32'(bus.PeriodOut), 40);
        tick(40);
        check("t1_code", 32'(bus.SpeedCode), 3'b010);
        check("t1_valid", 32'(bus.Valid), 1);
        check("t1_period", 32'(bus.PeriodOut), 40);

        tick(20);
        check("t2_unlock_valid", 32'(bus.Valid), 0);
        tick(20);
        check("t2_code001", 32'(bus.SpeedCode), 3'b001);
        tick(80);
        check("t2_after1_valid", 32'(bus.Valid), 0);
        check("t2_after1_code", 32'(bus.SpeedCode), 0);
        check("t2_after1_period", 32'(bus.PeriodOut), 80);
        tick(80);
        check("t2_code100", 32'(bus.SpeedCode), 3'b100);
        check("t2_valid", 32'(bus.Valid), 1);

        tick(40);
        tick(40);
        check("t3_lock010", 32'(bus.SpeedCode), 3'b010);
        tick(42);
        check("t3_tol_valid", 32'(bus.Valid), 1);
        check("t3_tol_code", 32'(bus.SpeedCode), 3'b010);
        check("t3_tol_period", 32'(bus.PeriodOut), 42);
        tick(43);
        check("t3_out_valid", 32'(bus.Valid), 0);
        check("t3_out_code", 32'(bus.SpeedCode), 0);
        check("t3_out_period", 32'(bus.PeriodOut), 43);

        tick(80);
        tick(80);
        check("t4_lock100", 32'(bus.SpeedCode), 3'b100);
        repeat (82) @(negedge clk);
        check("t4_pre_lost", 32'(bus.Lost), 0);
        check("t4_pre_valid", 32'(bus.Valid), 1);
        @(negedge clk);
        check("t4_lost", 32'(bus.Lost), 1);
        check("t4_valid", 32'(bus.Valid), 0);
        check("t4_code", 32'(bus.SpeedCode), 0);
        check("t4_period_hold", 32'(bus.PeriodOut), 80);
        tick(5);
        check("t4_lost_clr", 32'(bus.Lost), 0);
        check("t4_period_wait", 32'(bus.PeriodOut), 80);
        tick(40);
        tick(40);
        check("t4_relock", 32'(bus.SpeedCode), 3'b010);

        tick(83);
        check("tie_valid", 32'(bus.Valid), 0);
        check("tie_lost", 32'(bus.Lost), 0);
        check("tie_period", 32'(bus.PeriodOut), 83);

        tick(40);
        tick(40);
        check("t5_locked", 32'(bus.Valid), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_async_code", 32'(bus.SpeedCode), 0);
        check("t5_async_valid", 32'(bus.Valid), 0);
        check("t5_async_period", 32'(bus.PeriodOut), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        tick(20);
        check("t5_two_edges", 32'(bus.Valid), 0);
        tick(20);
        check("t5_relock", 32'(bus.SpeedCode), 3'b001);
        check("t5_valid", 32'(bus.Valid), 1);

        repeat (19) @(negedge clk);
        bus.TickIn = 1'b1;
        repeat (6) @(negedge clk);
        bus.TickIn = 1'b0;
        check("held_valid", 32'(bus.Valid), 1);
        check("held_period", 32'(bus.PeriodOut), 20);
        repeat (14) @(negedge clk);
        bus.TickIn = 1'b1;
        @(negedge clk);
        bus.TickIn = 1'b0;
        check("held_next_period", 32'(bus.PeriodOut), 20);
        check("held_next_valid", 32'(bus.Valid), 1);

`ifdef SPEED_TICK_DECODER_STATS_EN
        pulse_reset();
        tick(1);
        tick(40);
        tick(40);
        check("t6_chg1", 32'(bus.ChangeCount), 1);
        tick(80);
        tick(80);
        tick(20);
        tick(20);
        check("t6_code", 32'(bus.SpeedCode), 3'b001);
        check("t6_chg3", 32'(bus.ChangeCount), 3);
        repeat (83) @(negedge clk);
        check("t6_lost", 32'(bus.Lost), 1);
        tick(1);
        tick(20);
        tick(20);
        check("t6_relock", 32'(bus.SpeedCode), 3'b001);
        check("t6_chg_same", 32'(bus.ChangeCount), 3);
`else
        pulse_reset();
        check("final_reset", 32'(bus.Valid), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
